// File: rtl/stopwatch_uart_reporter.sv
// rtl/stopwatch_uart_reporter.sv - snapshots BCD stopwatch digits and sends "M:SS.T\r\n" as 8N1 UART frames
// Optional macro AUTO_REPORT_EN: also start a report whenever d0 changes, queuing at most one.
module stopwatch_uart_reporter #(
    parameter int BAUD_DVSR = 868,
    parameter int CHAR_CNT  = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       send,
    input  logic [3:0] d3,
    input  logic [3:0] d2,
    input  logic [3:0] d1,
    input  logic [3:0] d0,
    output logic       tx,
    output logic       busy,
    output logic       done_tick
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam logic [15:0] BAUD_LAST = 16'(BAUD_DVSR - 1);
    localparam logic [2:0]  LAST_CHAR = 3'(CHAR_CNT - 1);

    state_t      state_q, state_d;
    logic [15:0] baud_q, baud_d;
    logic [2:0]  bit_q, bit_d;
    logic [2:0]  char_q, char_d;
    logic [15:0] snap_q, snap_d;
    logic        tx_q, tx_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        req;
    logic        bit_end;
    logic [2:0]  next_bit;
    logic [7:0]  cur_char;

    function automatic logic [7:0] to_ascii(input logic [3:0] x);
        if (x <= 4'd9) begin
            return 8'h30 + {4'h0, x};
        end
        return 8'h3F;
    endfunction

`ifdef AUTO_REPORT_EN
    logic       pending_q, pending_d;
    logic [3:0] d0_last_q;

    assign req = send | pending_q | (d0 != d0_last_q);

    always_comb begin
        pending_d = pending_q | req;
        if (state_q == IDLE && req) begin
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= 1'b0;
            d0_last_q <= 4'd0;
        end else begin
            pending_q <= pending_d;
            d0_last_q <= d0;
        end
    end
`else
    assign req = send;
`endif

    always_comb begin
        cur_char = 8'h0A;
        case (char_q)
            3'd0:    cur_char = to_ascii(snap_q[15:12]);
            3'd1:    cur_char = 8'h3A;
            3'd2:    cur_char = to_ascii(snap_q[11:8]);
            3'd3:    cur_char = to_ascii(snap_q[7:4]);
            3'd4:    cur_char = 8'h2E;
            3'd5:    cur_char = to_ascii(snap_q[3:0]);
            3'd6:    cur_char = 8'h0D;
            default: cur_char = 8'h0A;
        endcase
    end

    assign bit_end  = (baud_q == BAUD_LAST);
    assign next_bit = bit_q + 3'd1;

    always_comb begin
        state_d = state_q;
        baud_d  = bit_end ? 16'd0 : baud_q + 16'd1;
        bit_d   = bit_q;
        char_d  = char_q;
        snap_d  = snap_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                baud_d = 16'd0;
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (req) begin
                    snap_d  = {d3, d2, d1, d0};
                    char_d  = 3'd0;
                    state_d = START;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    bit_d   = 3'd0;
                    tx_d    = cur_char[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = next_bit;
                        tx_d  = cur_char[next_bit];
                    end
                end
            end
            default: begin
                // Frames run back to back; only the last stop bit returns to IDLE.
                if (bit_end) begin
                    if (char_q == LAST_CHAR) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        tx_d    = 1'b1;
                    end else begin
                        char_d  = char_q + 3'd1;
                        state_d = START;
                        tx_d    = 1'b0;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            baud_q  <= 16'd0;
            bit_q   <= 3'd0;
            char_q  <= 3'd0;
            snap_q  <= 16'd0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            char_q  <= char_d;
            snap_q  <= snap_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign tx        = tx_q;
    assign busy      = busy_q;
    assign done_tick = done_q;

endmodule

// File: tb/tb_stopwatch_uart_reporter.sv
// tb/tb_stopwatch_uart_reporter.sv - directed self-checking bench for stopwatch_uart_reporter (BAUD_DVSR=4)
// Build with AUTO_REPORT_EN defined to exercise the automatic-report sequence instead of the default one.
module tb_stopwatch_uart_reporter;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       send = 1'b0;
    logic [3:0] d3 = 4'd0, d2 = 4'd0, d1 = 4'd0, d0 = 4'd0;
    logic       tx, busy, done_tick;

    int checks = 0;
    int errors = 0;

    stopwatch_uart_reporter #(.BAUD_DVSR(D), .CHAR_CNT(8)) dut (
        .clk(clk), .rst_n(rst_n), .send(send),
        .d3(d3), .d2(d2), .d1(d1), .d0(d0),
        .tx(tx), .busy(busy), .done_tick(done_tick)
    );

    always #5 clk = ~clk;

    // Independent UART receiver: samples each bit at its first negedge.
    logic [7:0] rx_q[$];
    int         start_cyc[$];
    int         cyc = 0;
    int         done_cnt = 0;
    int         stop_err = 0;
    bit         rst_hit = 1'b0;
    logic [7:0] mon_b;
    logic       mon_stp;
    int         mon_s;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (done_tick === 1'b1) done_cnt <= done_cnt + 1;
    end

    always @(negedge rst_n) rst_hit = 1'b1;

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tx === 1'b0) begin
                mon_s   = cyc;
                rst_hit = 1'b0;
                for (int i = 0; i < 9; i++) begin
                    repeat (D) @(negedge clk);
                    if (i < 8) mon_b[i] = tx;
                    else mon_stp = tx;
                end
                if (!rst_hit && rst_n === 1'b1) begin
                    rx_q.push_back(mon_b);
                    start_cyc.push_back(mon_s);
                    if (mon_stp !== 1'b1) stop_err++;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, observed running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_send();
        @(negedge clk);
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
    endtask

    // Counts negedges with busy high, starting at the current one.
    task automatic run_until_idle(input string tag, output int busy_cycles);
        int n;
        busy_cycles = 0;
        n = 0;
        while (busy === 1'b1 && n < 1000) begin
            busy_cycles++;
            @(negedge clk);
            n++;
        end
        chk({tag, "_idle_reached"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic check_report(input string tag, input int base, input logic [7:0] e [8]);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("%s_byte%0d", tag, i), {24'd0, rx_q[base + i]}, {24'd0, e[i]});
        end
    endtask

    logic [7:0] exp_a [8] = '{8'h33, 8'h3A, 8'h34, 8'h35, 8'h2E, 8'h37, 8'h0D, 8'h0A};
    logic [7:0] exp_c [8] = '{8'h33, 8'h3A, 8'h34, 8'h3F, 8'h2E, 8'h37, 8'h0D, 8'h0A};
    logic [7:0] exp_r1[8] = '{8'h30, 8'h3A, 8'h30, 8'h30, 8'h2E, 8'h31, 8'h0D, 8'h0A};
    logic [7:0] exp_r2[8] = '{8'h30, 8'h3A, 8'h30, 8'h30, 8'h2E, 8'h32, 8'h0D, 8'h0A};

    initial begin
        int bc;
        int lows;
        int dc0;

        repeat (3) @(negedge clk);
        chk("reset_tx", {31'd0, tx}, 32'd1);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done_tick}, 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_tx", {31'd0, tx}, 32'd1);
        chk("idle_busy", {31'd0, busy}, 32'd0);

`ifndef AUTO_REPORT_EN
        // Basic report with a one-cycle send pulse.
        d3 = 4'd3; d2 = 4'd4; d1 = 4'd5; d0 = 4'd7;
        rx_q.delete(); start_cyc.delete();
        dc0 = done_cnt;
        pulse_send();
        chk("t1_busy_start", {31'd0, busy}, 32'd1);
        chk("t1_tx_start", {31'd0, tx}, 32'd0);
        run_until_idle("t1", bc);
        chk("t1_busy_cycles", bc, 320);
        chk("t1_done_on_fall", {31'd0, done_tick}, 32'd1);
        @(negedge clk);
        chk("t1_done_one_cycle", {31'd0, done_tick}, 32'd0);
        repeat (10) @(negedge clk);
        chk("t1_done_count", done_cnt - dc0, 1);
        chk("t1_bytes", rx_q.size(), 8);
        check_report("t1", 0, exp_a);

        // Digits change after acceptance; a mid-report send is ignored.
        rx_q.delete(); start_cyc.delete();
        pulse_send();
        d3 = 4'd9; d2 = 4'd5; d1 = 4'd9; d0 = 4'd9;
        repeat (100) @(negedge clk);
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        run_until_idle("t2", bc);
        repeat (400) @(negedge clk);
        chk("t2_busy_after", {31'd0, busy}, 32'd0);
        chk("t2_bytes", rx_q.size(), 8);
        check_report("t2", 0, exp_a);

        // Non-decimal digit is sent as '?'.
        d3 = 4'd3; d2 = 4'd4; d1 = 4'hC; d0 = 4'd7;
        rx_q.delete(); start_cyc.delete();
        pulse_send();
        run_until_idle("t3", bc);
        repeat (10) @(negedge clk);
        chk("t3_bytes", rx_q.size(), 8);
        check_report("t3", 0, exp_c);

        // Asynchronous reset in DATA bit 3 of character 2 ('4', bit 3 = 0).
        d3 = 4'd3; d2 = 4'd4; d1 = 4'd5; d0 = 4'd7;
        rx_q.delete(); start_cyc.delete();
        pulse_send();
        repeat (97) @(negedge clk);
        chk("t4_pre_reset_tx", {31'd0, tx}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("t4_reset_tx", {31'd0, tx}, 32'd1);
        chk("t4_reset_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        lows = 0;
        repeat (200) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        chk("t4_tx_low_after", lows, 0);
        chk("t4_busy_after", {31'd0, busy}, 32'd0);
        chk("t4_bytes", rx_q.size(), 2);

        // send held high: two back-to-back reports one idle cycle apart.
        rx_q.delete(); start_cyc.delete();
        dc0 = done_cnt;
        @(negedge clk);
        send = 1'b1;
        repeat (600) @(negedge clk);
        send = 1'b0;
        run_until_idle("t5", bc);
        repeat (400) @(negedge clk);
        chk("t5_bytes", rx_q.size(), 16);
        check_report("t5a", 0, exp_a);
        check_report("t5b", 8, exp_a);
        chk("t5_gap", start_cyc[8] - start_cyc[7], 41);
        chk("t5_done_count", done_cnt - dc0, 2);
`else
        // d0 change starts a report; a change during it queues exactly one more.
        rx_q.delete(); start_cyc.delete();
        dc0 = done_cnt;
        @(negedge clk);
        d0 = 4'd1;
        @(negedge clk);
        chk("a_busy_start", {31'd0, busy}, 32'd1);
        repeat (99) @(negedge clk);
        d0 = 4'd2;
        run_until_idle("a1", bc);
        chk("a1_busy_cycles", bc, 320);
        chk("a1_done", {31'd0, done_tick}, 32'd1);
        @(negedge clk);
        chk("a2_busy_restart", {31'd0, busy}, 32'd1);
        run_until_idle("a2", bc);
        chk("a2_busy_cycles", bc, 320);
        repeat (400) @(negedge clk);
        chk("a_busy_after", {31'd0, busy}, 32'd0);
        chk("a_bytes", rx_q.size(), 16);
        check_report("a1", 0, exp_r1);
        check_report("a2", 8, exp_r2);
        chk("a_gap", start_cyc[8] - start_cyc[7], 41);
        chk("a_done_count", done_cnt - dc0, 2);
`endif

        chk("stop_bits", stop_err, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
